// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and jointly debounces encoder phases A/B,
// then turns each accepted Gray-code step into an EN pulse plus UpDown direction.
module quad_step_decoder #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       MR,
  input  logic       A,
  input  logic       B,
  input  logic       ERR_CLR,
  output logic       EN,
  output logic       UpDown,
  output logic       ERR,
  output logic       VALID,
  output logic [1:0] PHASE,
  output logic       dbg_state
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [7:0] DEB_M1 = 8'(DEB_CYCLES - 1);

  logic [1:0] sync1;
  logic [1:0] s;
  logic [1:0] s_prev;
  logic [1:0] f;
  logic [1:0] f_nxt;
  logic [7:0] dc;
  logic [7:0] dc_nxt;
  logic       upd;
  logic       upd_nxt;

  state_t     state;
  state_t     state_nxt;
  logic       en_nxt;
  logic       ud_nxt;
  logic       err_nxt;
  logic [1:0] phase_nxt;
  logic [1:0] step;

  // Position of a phase on the forward ring 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] ring_pos(input logic [1:0] p);
    case (p)
      2'b00:   ring_pos = 2'd0;
      2'b10:   ring_pos = 2'd1;
      2'b11:   ring_pos = 2'd2;
      default: ring_pos = 2'd3;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      sync1  <= 2'b00;
      s      <= 2'b00;
      s_prev <= 2'b00;
      f      <= 2'b00;
      dc     <= 8'd0;
      upd    <= 1'b0;
    end else begin
      sync1  <= {A, B};
      s      <= sync1;
      s_prev <= s;
      f      <= f_nxt;
      dc     <= dc_nxt;
      upd    <= upd_nxt;
    end
  end

  // The cycle on which s first shows a new value counts as dc = 0, so a pair
  // is accepted once it has been seen for DEB_CYCLES consecutive cycles.
  always_comb begin
    dc_nxt  = dc;
    f_nxt   = f;
    upd_nxt = 1'b0;
    if (s == f) begin
      dc_nxt = 8'd0;
    end else begin
      if (s != s_prev) dc_nxt = 8'd0;
      else             dc_nxt = dc + 8'd1;
      if (dc_nxt == DEB_M1) begin
        f_nxt   = s;
        dc_nxt  = 8'd0;
        upd_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state  <= ST_INIT;
      EN     <= 1'b0;
      UpDown <= 1'b0;
      ERR    <= 1'b0;
      PHASE  <= 2'b00;
    end else begin
      state  <= state_nxt;
      EN     <= en_nxt;
      UpDown <= ud_nxt;
      ERR    <= err_nxt;
      PHASE  <= phase_nxt;
    end
  end

  assign step = ring_pos(f) - ring_pos(PHASE);

  // ring step 1 = forward, 3 = reverse, 2 = both bits flipped (illegal).
  always_comb begin
    state_nxt = state;
    phase_nxt = PHASE;
    en_nxt    = 1'b0;
    ud_nxt    = UpDown;
    err_nxt   = ERR_CLR ? 1'b0 : ERR;
    case (state)
      ST_INIT: begin
        if (upd) begin
          phase_nxt = f;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (upd) begin
          phase_nxt = f;
          case (step)
            2'd1: begin
              en_nxt = 1'b1;
              ud_nxt = 1'b0;
            end
            2'd3: begin
              en_nxt = 1'b1;
              ud_nxt = 1'b1;
            end
            2'd2:    err_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign VALID     = (state == ST_TRACK);
  assign dbg_state = state;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed encoder scenarios plus random rotation,
// compared cycle by cycle against a run-length / ring-position reference model.
module tb_quad_step_decoder;

  localparam int DEB = 4;

  logic       CLK = 1'b0;
  logic       MR;
  logic       A;
  logic       B;
  logic       ERR_CLR;
  logic       EN;
  logic       UpDown;
  logic       ERR;
  logic       VALID;
  logic [1:0] PHASE;
  logic       dbg_state;

  int checks = 0;
  int failures = 0;

  quad_step_decoder #(.DEB_CYCLES(DEB)) dut (
    .CLK       (CLK),
    .MR        (MR),
    .A         (A),
    .B         (B),
    .ERR_CLR   (ERR_CLR),
    .EN        (EN),
    .UpDown    (UpDown),
    .ERR       (ERR),
    .VALID     (VALID),
    .PHASE     (PHASE),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [1:0] m_run_val = 2'b00;
  int         m_run_len = 1000;
  logic [1:0] m_f       = 2'b00;
  logic [1:0] m_phase   = 2'b00;
  logic       m_valid   = 1'b0;
  logic       m_err     = 1'b0;
  logic       m_ud      = 1'b0;
  logic       m_en      = 1'b0;
  int         cyc       = 0;
  logic [1:0] exp_q[$];
  int         due_q[$];

  function automatic int ring(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge CLK or posedge MR) begin
    logic [1:0] smp;
    logic [1:0] nv;
    int         d;
    int         tmp;
    logic       set;
    if (MR) begin
      m_run_val = 2'b00;
      m_run_len = 1000;
      m_f       = 2'b00;
      m_phase   = 2'b00;
      m_valid   = 1'b0;
      m_err     = 1'b0;
      m_ud      = 1'b0;
      m_en      = 1'b0;
      cyc       = 0;
      exp_q.delete();
      due_q.delete();
    end else begin
      cyc++;
      m_en = 1'b0;
      set  = 1'b0;
      smp  = {A, B};
      if (smp == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = smp;
        m_run_len = 1;
      end
      // A pair seen DEB times in a row is accepted; outputs follow 3 edges later.
      if (m_run_len == DEB && smp != m_f) begin
        m_f = smp;
        exp_q.push_back(smp);
        due_q.push_back(cyc + 3);
      end
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        nv  = exp_q.pop_front();
        tmp = due_q.pop_front();
        if (!m_valid) begin
          m_valid = 1'b1;
        end else begin
          d = (ring(nv) - ring(m_phase) + 4) % 4;
          if (d == 1) begin
            m_en = 1'b1;
            m_ud = 1'b0;
          end else if (d == 3) begin
            m_en = 1'b1;
            m_ud = 1'b1;
          end else if (d == 2) begin
            m_err = 1'b1;
            set   = 1'b1;
          end
        end
        m_phase = nv;
      end
      if (!set && ERR_CLR) m_err = 1'b0;
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  int         en_cnt = 0;
  logic [3:0] q = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    check("en",     32'(EN),        32'(m_en));
    check("updown", 32'(UpDown),    32'(m_ud));
    check("err",    32'(ERR),       32'(m_err));
    check("valid",  32'(VALID),     32'(m_valid));
    check("phase",  32'(PHASE),     32'(m_phase));
    check("dbg",    32'(dbg_state), 32'(m_valid));
    if (EN === 1'b1) begin
      en_cnt++;
      q = UpDown ? q - 4'h1 : q + 4'h1;
    end
  endtask

  task automatic step(input logic [1:0] v, input int n, output int lat);
    {A, B} = v;
    lat = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (EN === 1'b1 && lat < 0) lat = i - 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    32'(EN),     32'd0);
    check({tag, "_ud"},    32'(UpDown), 32'd0);
    check({tag, "_err"},   32'(ERR),    32'd0);
    check({tag, "_valid"}, 32'(VALID),  32'd0);
    check({tag, "_phase"}, 32'(PHASE),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] fwd_seq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [3:0] fwd_q[4]   = '{4'hF, 4'h0, 4'h1, 4'h2};
  logic [1:0] rev_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [3:0] rev_q[4]   = '{4'h0, 4'hF, 4'hE, 4'hD};

  initial begin
    int lat;
    int n;
    int hold;
    logic found;
    MR = 1'b1;
    A = 1'b1;
    B = 1'b1;
    ERR_CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");

    // Power-up capture of 11.
    @(negedge CLK);
    MR = 1'b0;
    en_cnt = 0;
    n = 0;
    tick();
    while (VALID !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("pwr_lat", 32'(n), 32'(DEB + 2));
    check("pwr_phase", 32'(PHASE), 32'd3);
    check("pwr_no_en", 32'(en_cnt), 32'd0);
    check("pwr_no_err", 32'(ERR), 32'd0);

    step(2'b01, 10, lat);
    step(2'b00, 10, lat);

    // Forward rotation driving the counter from 0xE.
    q = 4'hE;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(fwd_seq[i], 10, lat);
      check("fwd_lat", 32'(lat), 32'(DEB + 2));
      check("fwd_ud", 32'(UpDown), 32'd0);
      check("fwd_q", 32'(q), 32'(fwd_q[i]));
    end
    check("fwd_cnt", 32'(en_cnt), 32'd4);

    // Bounce rejection on A, starting from 00.
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 3, lat);
      step(2'b00, 3, lat);
    end
    step(2'b10, 12, lat);
    check("bnc_cnt", 32'(en_cnt), 32'd1);
    check("bnc_lat", 32'(lat), 32'(DEB + 2));
    check("bnc_ud", 32'(UpDown), 32'd0);

    // Walk back to 01, then jump 01 -> 10.
    step(2'b00, 10, lat);
    step(2'b01, 10, lat);
    en_cnt = 0;
    step(2'b10, 10, lat);
    check("ill_err", 32'(ERR), 32'd1);
    check("ill_no_en", 32'(en_cnt), 32'd0);
    check("ill_phase", 32'(PHASE), 32'd2);

    // Clear coinciding with a second illegal step loses.
    {A, B} = 2'b01;
    repeat (6) tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("clr_lose_err", 32'(ERR), 32'd1);
    check("clr_lose_phase", 32'(PHASE), 32'd1);
    repeat (4) tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    check("clr_err", 32'(ERR), 32'd0);

    // Reverse rotation driving the counter from 0x1.
    step(2'b00, 10, lat);
    q = 4'h1;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(rev_seq[i], 10, lat);
      check("rev_lat", 32'(lat), 32'(DEB + 2));
      check("rev_ud", 32'(UpDown), 32'd1);
      check("rev_q", 32'(q), 32'(rev_q[i]));
    end
    check("rev_cnt", 32'(en_cnt), 32'd4);

    // Reset during a reverse EN pulse.
    {A, B} = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (EN === 1'b1) found = 1'b1;
    end
    check("mr_pulse_seen", 32'(found), 32'd1);
    check("mr_pulse_ud", 32'(UpDown), 32'd1);
    #2 MR = 1'b1;
    #1;
    check_reset_outputs("mr_pulse");
    @(negedge CLK);
    MR = 1'b0;
    en_cnt = 0;
    repeat (15) tick();
    check("mr_pulse_no_en", 32'(en_cnt), 32'd0);
    check("mr_pulse_valid", 32'(VALID), 32'd1);
    check("mr_pulse_phase", 32'(PHASE), 32'd1);

    // Reset mid-debounce.
    {A, B} = 2'b11;
    repeat (3) tick();
    #2 MR = 1'b1;
    #1;
    check_reset_outputs("mr_deb");
    @(negedge CLK);
    MR = 1'b0;
    en_cnt = 0;
    repeat (15) tick();
    check("mr_deb_no_en", 32'(en_cnt), 32'd0);
    check("mr_deb_valid", 32'(VALID), 32'd1);
    check("mr_deb_phase", 32'(PHASE), 32'd3);

    // Random rotation with bounces, jumps and occasional clears.
    repeat (250) begin
      {A, B} = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      repeat (hold) begin
        ERR_CLR = ($urandom_range(0, 7) == 0);
        tick();
      end
      ERR_CLR = 1'b0;
    end
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
